// File: rtl/e203_fpu_sbd_ctrl.sv
// ---------------------------------------------------------------------------
// e203_fpu_sbd_ctrl
// Dispatch-side scoreboard for long-latency FPU operations. It tracks which FP
// and integer registers have an FPU result still in flight, stalls dispatch on
// RAW/WAW hazards against those pending results, and limits the number of
// outstanding allocating FPU ops to MAX_OUTS.
//
// Ports:
//   clk, rst_n              core clock, asynchronous active-low reset
//   disp_*                  decoded instruction (sources, destination, FPU flag)
//   disp_ready              instruction may dispatch this cycle
//   wbck_valid/rdfpu/rdidx  FPU writeback completion; wbck_ready is always 1
//   fbusy_vec, xbusy_vec    registered busy bits of FP / integer files
//   outs_cnt, sbd_empty     in-flight allocating op count, and count == 0
//   stall_cause             00 none, 01 RAW, 10 WAW, 11 outstanding limit
//   err_sticky              a writeback hit a register that was not busy
// ---------------------------------------------------------------------------
module e203_fpu_sbd_ctrl #(
    parameter int RFIDX_W  = 5,
    parameter int MAX_OUTS = 4,
    parameter int CNT_W    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               disp_valid,
    output logic               disp_ready,
    input  logic               disp_fp_en,
    input  logic               disp_frs1en,
    input  logic               disp_frs2en,
    input  logic               disp_frs3en,
    input  logic [RFIDX_W-1:0] disp_frs1idx,
    input  logic [RFIDX_W-1:0] disp_frs2idx,
    input  logic [RFIDX_W-1:0] disp_frs3idx,
    input  logic               disp_rs1en,
    input  logic               disp_rs2en,
    input  logic [RFIDX_W-1:0] disp_rs1idx,
    input  logic [RFIDX_W-1:0] disp_rs2idx,
    input  logic               disp_rdwen,
    input  logic [RFIDX_W-1:0] disp_rdidx,
    input  logic               disp_rdfpu,
    input  logic               wbck_valid,
    output logic               wbck_ready,
    input  logic               wbck_rdfpu,
    input  logic [RFIDX_W-1:0] wbck_rdidx,
    output logic [31:0]        fbusy_vec,
    output logic [31:0]        xbusy_vec,
    output logic [CNT_W-1:0]   outs_cnt,
    output logic               sbd_empty,
    output logic [1:0]         stall_cause,
    output logic               err_sticky
);

    logic [31:0]      fbusy_r;
    logic [31:0]      xbusy_r;
    logic [CNT_W-1:0] cnt_r;
    logic             err_r;

    logic             raw_s;
    logic             waw_s;
    logic             full_s;
    logic             ready_s;
    logic             rd_is_x0_s;
    logic             alloc_s;
    logic             rel_s;
    logic             spurious_s;
    logic [31:0]      alloc_mask_s;
    logic [31:0]      rel_mask_s;
    logic [31:0]      fbusy_nxt_s;
    logic [31:0]      xbusy_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Hazard detection against registered busy bits only (no writeback bypass).
    always_comb begin
        raw_s = (disp_frs1en & fbusy_r[disp_frs1idx])
              | (disp_frs2en & fbusy_r[disp_frs2idx])
              | (disp_frs3en & fbusy_r[disp_frs3idx])
              | (disp_rs1en & (disp_rs1idx != {RFIDX_W{1'b0}}) & xbusy_r[disp_rs1idx])
              | (disp_rs2en & (disp_rs2idx != {RFIDX_W{1'b0}}) & xbusy_r[disp_rs2idx]);
        rd_is_x0_s = ~disp_rdfpu & (disp_rdidx == {RFIDX_W{1'b0}});
        waw_s  = disp_rdwen & ~rd_is_x0_s
               & (disp_rdfpu ? fbusy_r[disp_rdidx] : xbusy_r[disp_rdidx]);
        full_s = disp_fp_en & disp_rdwen & (cnt_r == CNT_W'(MAX_OUTS));
        ready_s = ~(raw_s | waw_s | full_s);
    end

    // Stall cause encoding, RAW has highest priority, then WAW, then full.
    always_comb begin
        stall_cause = 2'b00;
        if (raw_s) begin
            stall_cause = 2'b01;
        end else if (waw_s) begin
            stall_cause = 2'b10;
        end else if (full_s) begin
            stall_cause = 2'b11;
        end else begin
            stall_cause = 2'b00;
        end
    end

    // Allocation/release decode and next busy/counter state.
    // A write to x0 never marks anything busy, so it is not counted either;
    // counting it would leave an entry no writeback could ever release.
    always_comb begin
        alloc_s      = disp_valid & ready_s & disp_fp_en & disp_rdwen & ~rd_is_x0_s;
        rel_s        = wbck_valid & (wbck_rdfpu ? fbusy_r[wbck_rdidx] : xbusy_r[wbck_rdidx]);
        spurious_s   = wbck_valid & ~rel_s;
        alloc_mask_s = alloc_s ? (32'd1 << disp_rdidx) : 32'd0;
        rel_mask_s   = rel_s ? (32'd1 << wbck_rdidx) : 32'd0;
        fbusy_nxt_s  = (fbusy_r | (disp_rdfpu ? alloc_mask_s : 32'd0))
                     & ~(wbck_rdfpu ? rel_mask_s : 32'd0);
        xbusy_nxt_s  = (xbusy_r | (disp_rdfpu ? 32'd0 : alloc_mask_s))
                     & ~(wbck_rdfpu ? 32'd0 : rel_mask_s);
        case ({alloc_s, rel_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
            2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Scoreboard state registers; reset drops all pending entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fbusy_r <= 32'd0;
            xbusy_r <= 32'd0;
            cnt_r   <= {CNT_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            fbusy_r <= fbusy_nxt_s;
            xbusy_r <= xbusy_nxt_s;
            cnt_r   <= cnt_nxt_s;
            err_r   <= err_r | spurious_s;
        end
    end

    assign disp_ready = ready_s;
    assign wbck_ready = 1'b1;
    assign fbusy_vec  = fbusy_r;
    assign xbusy_vec  = xbusy_r;
    assign outs_cnt   = cnt_r;
    assign sbd_empty  = (cnt_r == {CNT_W{1'b0}});
    assign err_sticky = err_r;

endmodule

// File: tb/tb_e203_fpu_sbd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_e203_fpu_sbd_ctrl
// Table-driven bench: each row is one cycle of dispatch/writeback stimulus with
// the expected combinational response (ready, stall cause) and the expected
// registered state after the following clock edge. Rows run back to back so
// state carries from one row to the next. A hand-written sequence covers an
// asynchronous reset with entries in flight and a spurious writeback after it.
// ---------------------------------------------------------------------------
module tb_e203_fpu_sbd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        disp_valid = 1'b0, disp_ready, disp_fp_en = 1'b0;
    logic        disp_frs1en = 1'b0, disp_frs2en = 1'b0, disp_frs3en = 1'b0;
    logic [4:0]  disp_frs1idx = 5'd0, disp_frs2idx = 5'd0, disp_frs3idx = 5'd0;
    logic        disp_rs1en = 1'b0, disp_rs2en = 1'b0;
    logic [4:0]  disp_rs1idx = 5'd0, disp_rs2idx = 5'd0;
    logic        disp_rdwen = 1'b0, disp_rdfpu = 1'b0;
    logic [4:0]  disp_rdidx = 5'd0;
    logic        wbck_valid = 1'b0, wbck_ready, wbck_rdfpu = 1'b0;
    logic [4:0]  wbck_rdidx = 5'd0;
    logic [31:0] fbusy_vec, xbusy_vec;
    logic [2:0]  outs_cnt;
    logic        sbd_empty, err_sticky;
    logic [1:0]  stall_cause;

    int errors = 0;
    int checks = 0;
    int row = -1;

    e203_fpu_sbd_ctrl #(.RFIDX_W(5), .MAX_OUTS(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_fp_en(disp_fp_en),
        .disp_frs1en(disp_frs1en), .disp_frs2en(disp_frs2en), .disp_frs3en(disp_frs3en),
        .disp_frs1idx(disp_frs1idx), .disp_frs2idx(disp_frs2idx), .disp_frs3idx(disp_frs3idx),
        .disp_rs1en(disp_rs1en), .disp_rs2en(disp_rs2en),
        .disp_rs1idx(disp_rs1idx), .disp_rs2idx(disp_rs2idx),
        .disp_rdwen(disp_rdwen), .disp_rdidx(disp_rdidx), .disp_rdfpu(disp_rdfpu),
        .wbck_valid(wbck_valid), .wbck_ready(wbck_ready),
        .wbck_rdfpu(wbck_rdfpu), .wbck_rdidx(wbck_rdidx),
        .fbusy_vec(fbusy_vec), .xbusy_vec(xbusy_vec), .outs_cnt(outs_cnt),
        .sbd_empty(sbd_empty), .stall_cause(stall_cause), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, fp;
        logic        f1e, f2e, f3e, r1e, r2e;
        logic [4:0]  f1i, f2i, f3i, r1i, r2i;
        logic        we, rfpu;
        logic [4:0]  rd;
        logic        wv, wfpu;
        logic [4:0]  wi;
        logic        rdy;
        logic [1:0]  cause;
        logic [31:0] fb, xb;
        logic [2:0]  cnt;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int v, int fp, int f1e, int f1i, int f2e, int f2i,
                                int f3e, int f3i, int r1e, int r1i, int r2e, int r2i,
                                int we, int rd, int rfpu, int wv, int wfpu, int wi,
                                int rdy, int cause, int fb, int xb, int cnt, int err);
        vec_t t;
        t.v = 1'(v);     t.fp = 1'(fp);
        t.f1e = 1'(f1e); t.f1i = 5'(f1i);
        t.f2e = 1'(f2e); t.f2i = 5'(f2i);
        t.f3e = 1'(f3e); t.f3i = 5'(f3i);
        t.r1e = 1'(r1e); t.r1i = 5'(r1i);
        t.r2e = 1'(r2e); t.r2i = 5'(r2i);
        t.we = 1'(we);   t.rd = 5'(rd);   t.rfpu = 1'(rfpu);
        t.wv = 1'(wv);   t.wfpu = 1'(wfpu); t.wi = 5'(wi);
        t.rdy = 1'(rdy); t.cause = 2'(cause);
        t.fb = 32'(fb);  t.xb = 32'(xb);  t.cnt = 3'(cnt); t.err = 1'(err);
        return t;
    endfunction

    task automatic apply(input vec_t t);
        disp_valid = t.v;   disp_fp_en = t.fp;
        disp_frs1en = t.f1e; disp_frs1idx = t.f1i;
        disp_frs2en = t.f2e; disp_frs2idx = t.f2i;
        disp_frs3en = t.f3e; disp_frs3idx = t.f3i;
        disp_rs1en = t.r1e;  disp_rs1idx = t.r1i;
        disp_rs2en = t.r2e;  disp_rs2idx = t.r2i;
        disp_rdwen = t.we;   disp_rdidx = t.rd;  disp_rdfpu = t.rfpu;
        wbck_valid = t.wv;   wbck_rdfpu = t.wfpu; wbck_rdidx = t.wi;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got 0x%0h, expected 0x%0h", name, row, act, exp);
        end
    endtask

    initial begin
        // Columns: v fp | f1e f1i f2e f2i f3e f3i | r1e r1i r2e r2i | we rd rfpu |
        //          wv wfpu wi | rdy cause | fbusy xbusy cnt err (after edge)
        vecs.push_back(mk(1,1, 0,0,0,0,0,0, 0,0,0,0, 1,5,1,  0,0,0, 1,0, 'h20,0,1,0)); // alloc f5
        vecs.push_back(mk(1,1, 0,0,1,5,0,0, 0,0,0,0, 1,6,1,  0,0,0, 0,1, 'h20,0,1,0)); // RAW f5
        vecs.push_back(mk(1,1, 0,0,1,5,0,0, 0,0,0,0, 1,6,1,  1,1,5, 0,1, 'h00,0,0,0)); // wb f5 same cycle: still stalled
        vecs.push_back(mk(1,1, 0,0,1,5,0,0, 0,0,0,0, 1,6,1,  0,0,0, 1,0, 'h40,0,1,0)); // next cycle fires, alloc f6
        vecs.push_back(mk(1,1, 0,0,0,0,0,0, 0,0,0,0, 1,6,1,  0,0,0, 0,2, 'h40,0,1,0)); // WAW f6
        vecs.push_back(mk(1,0, 0,0,0,0,0,0, 1,0,0,0, 1,0,0,  0,0,0, 1,0, 'h40,0,1,0)); // int op rd x0, rs1 x0
        vecs.push_back(mk(1,1, 0,0,0,0,0,0, 0,0,0,0, 1,0,0,  0,0,0, 1,0, 'h40,0,1,0)); // FP op -> x0: no alloc
        vecs.push_back(mk(1,1, 0,0,0,0,0,0, 0,0,0,0, 1,3,0,  0,0,0, 1,0, 'h40,8,2,0)); // FP op -> x3
        vecs.push_back(mk(1,0, 0,0,0,0,0,0, 0,0,1,3, 1,4,0,  0,0,0, 0,1, 'h40,8,2,0)); // RAW via rs2 x3
        vecs.push_back(mk(1,0, 0,0,0,0,0,0, 0,0,0,0, 1,3,0,  0,0,0, 0,2, 'h40,8,2,0)); // WAW x3
        vecs.push_back(mk(1,1, 0,0,0,0,1,6, 0,0,0,0, 1,10,1, 0,0,0, 0,1, 'h40,8,2,0)); // RAW via frs3 f6
        vecs.push_back(mk(1,1, 0,0,0,0,0,0, 0,0,0,0, 1,1,1,  0,0,0, 1,0, 'h42,8,3,0)); // alloc f1
        vecs.push_back(mk(1,1, 0,0,0,0,0,0, 0,0,0,0, 1,2,1,  0,0,0, 1,0, 'h46,8,4,0)); // alloc f2 -> limit
        vecs.push_back(mk(1,1, 0,0,0,0,0,0, 0,0,0,0, 1,9,1,  0,0,0, 0,3, 'h46,8,4,0)); // full
        vecs.push_back(mk(1,1, 1,1,0,0,0,0, 0,0,0,0, 1,9,1,  0,0,0, 0,1, 'h46,8,4,0)); // RAW beats full
        vecs.push_back(mk(1,0, 0,0,0,0,0,0, 0,0,0,0, 1,5,0,  1,1,1, 1,0, 'h44,8,3,0)); // int op fires + wb f1
        vecs.push_back(mk(1,1, 0,0,0,0,0,0, 0,0,0,0, 1,9,1,  0,0,0, 1,0, 'h244,8,4,0)); // FP rd f9 accepted
        vecs.push_back(mk(0,0, 0,0,0,0,0,0, 0,0,0,0, 0,0,0,  1,0,3, 1,0, 'h244,0,3,0)); // wb x3
        vecs.push_back(mk(1,1, 0,0,0,0,0,0, 0,0,0,0, 1,7,1,  1,1,2, 1,0, 'h2C0,0,3,0)); // alloc f7 + wb f2
        vecs.push_back(mk(0,0, 0,0,0,0,0,0, 0,0,0,0, 0,0,0,  1,0,3, 1,0, 'h2C0,0,3,1)); // spurious wb x3
        vecs.push_back(mk(0,1, 0,0,0,0,0,0, 0,0,0,0, 1,7,1,  0,0,0, 0,2, 'h2C0,0,3,1)); // WAW with valid=0
        vecs.push_back(mk(1,1, 0,0,0,0,0,0, 0,0,0,0, 1,0,1,  0,0,0, 1,0, 'h2C1,0,4,1)); // f0 is a normal reg
        vecs.push_back(mk(1,1, 0,0,0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0, 1,0, 'h2C1,0,4,1)); // FP store at limit
        vecs.push_back(mk(1,1, 0,0,0,0,0,0, 0,0,0,0, 1,8,1,  0,0,0, 0,3, 'h2C1,0,4,1)); // full again

        // Reset state
        #3;
        chk("rst_fbusy", fbusy_vec, 32'd0);
        chk("rst_xbusy", xbusy_vec, 32'd0);
        chk("rst_cnt", {29'd0, outs_cnt}, 32'd0);
        chk("rst_empty", {31'd0, sbd_empty}, 32'd1);
        chk("rst_ready", {31'd0, disp_ready}, 32'd1);
        chk("rst_wbck_ready", {31'd0, wbck_ready}, 32'd1);
        chk("rst_err", {31'd0, err_sticky}, 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            row = i;
            apply(vecs[i]);
            #3;
            chk("ready", {31'd0, disp_ready}, {31'd0, vecs[i].rdy});
            chk("cause", {30'd0, stall_cause}, {30'd0, vecs[i].cause});
            @(posedge clk); #1;
            chk("fbusy", fbusy_vec, vecs[i].fb);
            chk("xbusy", xbusy_vec, vecs[i].xb);
            chk("cnt", {29'd0, outs_cnt}, {29'd0, vecs[i].cnt});
            chk("empty", {31'd0, sbd_empty}, {31'd0, (vecs[i].cnt == 3'd0)});
            chk("err", {31'd0, err_sticky}, {31'd0, vecs[i].err});
        end

        // Mid-flight asynchronous reset clears everything without a clock edge.
        row = 100;
        apply(mk(0,0, 0,0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,0));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_fbusy", fbusy_vec, 32'd0);
        chk("mid_rst_xbusy", xbusy_vec, 32'd0);
        chk("mid_rst_cnt", {29'd0, outs_cnt}, 32'd0);
        chk("mid_rst_err", {31'd0, err_sticky}, 32'd0);
        chk("mid_rst_empty", {31'd0, sbd_empty}, 32'd1);
        chk("mid_rst_cause", {30'd0, stall_cause}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // A writeback for an entry dropped by reset is spurious.
        row = 101;
        wbck_valid = 1'b1; wbck_rdfpu = 1'b1; wbck_rdidx = 5'd9;
        @(posedge clk); #1;
        wbck_valid = 1'b0;
        chk("post_rst_wb_err", {31'd0, err_sticky}, 32'd1);
        chk("post_rst_wb_cnt", {29'd0, outs_cnt}, 32'd0);
        chk("post_rst_wb_fbusy", fbusy_vec, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/e203_fpu_sbd_ctrl.md
Name: e203_fpu_sbd_ctrl

Overview:
Dispatch-side scoreboard controller for long-latency FPU operations in the E203 EXU. It sits between the decoder and the FPU issue path and marks FP and integer destination registers busy while an FPU op is in flight. It stalls dispatch on RAW and WAW hazards against pending FPU writebacks, and it caps the number of outstanding FPU ops. Writebacks from the FPU clear the busy entries.

Parameters:
RFIDX_W, 5, register index width (32 FP regs, 32 integer regs)
MAX_OUTS, 4, maximum in-flight FPU ops with a destination (1..7)
CNT_W, 3, width of the outstanding counter; must satisfy 2^CNT_W > MAX_OUTS

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
disp_valid  in  1  decoded instruction requests dispatch
disp_ready  out  1  dispatch accepted this cycle (fire = valid & ready)
disp_fp_en  in  1  instruction executes in the FPU
disp_frs1en / disp_frs2en / disp_frs3en  in  1 each  FP source operand used
disp_frs1idx / disp_frs2idx / disp_frs3idx  in  RFIDX_W each  FP source indices
disp_rs1en / disp_rs2en  in  1 each  integer source operand used
disp_rs1idx / disp_rs2idx  in  RFIDX_W each  integer source indices
disp_rdwen  in  1  instruction writes a destination
disp_rdidx  in  RFIDX_W  destination index
disp_rdfpu  in  1  destination is in the FP file (1) or integer file (0)
wbck_valid  in  1  FPU writeback completes this cycle
wbck_ready  out  1  always 1 after reset
wbck_rdfpu  in  1  writeback targets the FP file (1) or integer file (0)
wbck_rdidx  in  RFIDX_W  writeback index
fbusy_vec  out  32  FP register busy bits
xbusy_vec  out  32  integer register busy bits
outs_cnt  out  CNT_W  number of in-flight allocating ops
sbd_empty  out  1  outs_cnt == 0
stall_cause  out  2  00 none, 01 RAW, 10 WAW, 11 full
err_sticky  out  1  set by a writeback to a non-busy register

Behaviour:
- Reset (async, rst_n=0): fbusy_vec=0, xbusy_vec=0, outs_cnt=0, err_sticky=0. Consequently sbd_empty=1, disp_ready=1, stall_cause=00, wbck_ready=1.
- The register state is fbusy, xbusy, outs_cnt and err_sticky. Everything else is combinational from that state and the current-cycle inputs.
- RAW hazard, if any of the following holds:
  - any frsNen=1 with fbusy[frsNidx]=1;
  - rs1en=1 with xbusy[rs1idx]=1;
  - rs2en=1 with xbusy[rs2idx]=1.
  - These checks apply to all instructions, FP or not.
- WAW hazard: rdwen=1 and the destination's busy bit is set, in the file selected by rdfpu.
- Full: disp_fp_en=1, rdwen=1 and outs_cnt==MAX_OUTS.
- disp_ready = !(RAW | WAW | full). It is independent of disp_valid.
- stall_cause priority is RAW > WAW > full. It is evaluated whether or not disp_valid is asserted.
- Hazard checks use the registered busy bits only; there is no writeback bypass. A writeback in cycle N unblocks a dependent instruction in cycle N+1.
- Integer index 0 never becomes busy and never causes a hazard. FP index 0 is a normal register.
- Allocation: fire & disp_fp_en & rdwen. It sets the destination busy bit at the next edge and increments outs_cnt.
- Non-FPU instructions, and FPU instructions with rdwen=0 (e.g. FP stores), never allocate.
- Release: wbck_valid with the indexed busy bit set clears that bit at the next edge and decrements outs_cnt.
- A writeback to a non-busy bit changes no state except setting err_sticky. err_sticky is cleared only by reset.
- Allocation and release in the same cycle: both bit updates apply and outs_cnt is unchanged.
  - The same index cannot be both allocated and released in one cycle: allocation requires the bit to be clear (WAW), release requires it set.
- Counter bounds: outs_cnt never exceeds MAX_OUTS and never underflows (a release requires a set bit).
- Reset asserted mid-flight drops all pending entries immediately. Writebacks arriving after reset are treated as spurious and set err_sticky.

Test Plan:
- Reset, then dispatch FP op, rdfpu=1, rdidx=5 -> disp_ready=1; next cycle fbusy_vec=0x20, outs_cnt=1, sbd_empty=0.
- With f5 busy, dispatch frs2en=1, frs2idx=5 -> disp_ready=0, stall_cause=01. Writeback f5 in cycle N -> disp_ready=1 in N+1, not in N.
- With f5 busy, dispatch FP op rdidx=5, no sources -> stall_cause=10. Integer op with rdwen=1, rdidx=0 and an FPU integer writeback pending to x0 -> never stalls, xbusy_vec[0]=0.
- Allocate f1..f4 (MAX_OUTS=4), then FP op rdidx=9 -> stall_cause=11, outs_cnt=4. Same cycle: writeback f1 plus a non-FP integer dispatch -> integer op fires; next cycle outs_cnt=3 and FP op accepted.
- Same-cycle allocate f7 and writeback f2 (busy) -> next cycle fbusy[7]=1, fbusy[2]=0, outs_cnt unchanged.
- Writeback x3 while not busy -> err_sticky=1, outs_cnt unchanged. Assert rst_n=0 with 3 pending -> immediately all vectors 0, outs_cnt=0, err_sticky=0.
